// File: rtl/mcore_pkg.sv
// Shared definitions for the multi-cycle core: opcode values, FSM states
// and ALU operation selects.
package mcore_pkg;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h04;
    localparam logic [5:0] OP_ORI  = 6'h05;
    localparam logic [5:0] OP_LHI  = 6'h06;
    localparam logic [5:0] OP_LLI  = 6'h07;
    localparam logic [5:0] OP_LW   = 6'h08;
    localparam logic [5:0] OP_SW   = 6'h09;
    localparam logic [5:0] OP_BEQ  = 6'h0A;
    localparam logic [5:0] OP_JMP  = 6'h0B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_PASSB,
        ALU_EQ
    } alu_op_t;

endpackage

// File: rtl/mcore_alu.sv
// Combinational ALU for the multi-cycle core. The equality flag is always
// produced so branches can use it regardless of the selected operation.
module mcore_alu
    import mcore_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] i_a,
    input  logic [WORD_SIZE-1:0] i_b,
    input  alu_op_t              i_op,
    output logic [WORD_SIZE-1:0] o_result,
    output logic                 o_eq
);

    // Select the arithmetic/logic result; all arithmetic wraps modulo 2^WORD_SIZE
    always_comb begin
        o_eq     = (i_a == i_b);
        o_result = '0;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_PASSB: o_result = i_b;
            ALU_EQ:    o_result = {{(WORD_SIZE-1){1'b0}}, o_eq};
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/mcore_seq_datapath.sv
// Multi-cycle sequential core: FETCH/DECODE/EXEC/MEM/WB/HALT datapath with
// handshaked instruction and data ports. All interface outputs come from
// flops. Optional feature: define MCORE_RETIRE_CNT_EN to add the 'retired'
// output counting completed instructions.
module mcore_seq_datapath
    import mcore_pkg::*;
#(
    parameter int          WORD_SIZE = 32,
    parameter int          NUM_REGS  = 32,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ready,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [WORD_SIZE-1:0] dmem_addr,
    output logic [WORD_SIZE-1:0] dmem_wdata,
    input  logic                 dmem_ready,
    input  logic [WORD_SIZE-1:0] dmem_rdata,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] pc_out
`ifdef MCORE_RETIRE_CNT_EN
    ,
    output logic [WORD_SIZE-1:0] retired
`endif
);

    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t                r_state;
    state_t                w_nextState;

    logic [31:0]           r_ir;
    logic [WORD_SIZE-1:0]  r_pc;
    logic [WORD_SIZE-1:0]  r_a;
    logic [WORD_SIZE-1:0]  r_b;
    logic [WORD_SIZE-1:0]  r_aluOut;
    logic [WORD_SIZE-1:0]  r_mdr;
    logic [WORD_SIZE-1:0]  r_dmemAddr;
    logic [WORD_SIZE-1:0]  r_dmemWdata;
    logic                  r_imemReq;
    logic                  r_dmemReq;
    logic                  r_dmemWe;
    logic                  r_halted;
    logic [WORD_SIZE-1:0]  r_regs [NUM_REGS];

    logic [5:0]            w_opcode;
    logic [RIDX_W-1:0]     w_r1;
    logic [RIDX_W-1:0]     w_r2;
    logic [RIDX_W-1:0]     w_r3;
    logic [15:0]           w_imm;
    logic [WORD_SIZE-1:0]  w_immSe;
    logic [WORD_SIZE-1:0]  w_immZe;
    logic [WORD_SIZE-1:0]  w_r1Val;
    logic [WORD_SIZE-1:0]  w_aluA;
    logic [WORD_SIZE-1:0]  w_aluB;
    alu_op_t               w_aluOp;
    logic [WORD_SIZE-1:0]  w_aluResult;
    logic                  w_aluEq;
    logic                  w_fetchDone;
    logic                  w_memDone;
    logic                  w_imemReqNext;
    logic                  w_dmemReqNext;
    logic                  w_dmemWeNext;
    logic                  w_haltedNext;

    assign w_opcode = r_ir[31:26];
    assign w_r1     = r_ir[21 +: RIDX_W];
    assign w_r2     = r_ir[16 +: RIDX_W];
    assign w_r3     = r_ir[11 +: RIDX_W];
    assign w_imm    = r_ir[15:0];
    assign w_immSe  = {{(WORD_SIZE-16){w_imm[15]}}, w_imm};
    assign w_immZe  = {{(WORD_SIZE-16){1'b0}}, w_imm};
    assign w_r1Val  = r_regs[w_r1];

    // A ready is only honoured while our own request is actually up
    assign w_fetchDone = r_imemReq & imem_ready;
    assign w_memDone   = r_dmemReq & dmem_ready;

    assign imem_req   = r_imemReq;
    assign imem_addr  = r_pc;
    assign pc_out     = r_pc;
    assign dmem_req   = r_dmemReq;
    assign dmem_we    = r_dmemWe;
    assign dmem_addr  = r_dmemAddr;
    assign dmem_wdata = r_dmemWdata;
    assign halted     = r_halted;

    // Pick ALU operands and operation for the instruction held in IR
    always_comb begin
        w_aluA  = r_a;
        w_aluB  = r_b;
        w_aluOp = ALU_ADD;
        case (w_opcode)
            OP_ADD:  w_aluOp = ALU_ADD;
            OP_SUB:  w_aluOp = ALU_SUB;
            OP_AND:  w_aluOp = ALU_AND;
            OP_OR:   w_aluOp = ALU_OR;
            OP_ADDI: begin
                w_aluB  = w_immSe;
                w_aluOp = ALU_ADD;
            end
            OP_ORI: begin
                w_aluB  = w_immZe;
                w_aluOp = ALU_OR;
            end
            OP_LHI: begin
                w_aluB        = '0;
                w_aluB[31:0]  = {w_imm, w_r1Val[15:0]};
                w_aluOp       = ALU_PASSB;
            end
            OP_LLI: begin
                w_aluB  = {w_r1Val[WORD_SIZE-1:16], w_imm};
                w_aluOp = ALU_PASSB;
            end
            OP_LW, OP_SW: begin
                w_aluB  = w_immSe;
                w_aluOp = ALU_ADD;
            end
            OP_BEQ:  w_aluOp = ALU_EQ;
            default: w_aluOp = ALU_ADD;
        endcase
    end

    mcore_alu #(
        .WORD_SIZE (WORD_SIZE)
    ) u_alu (
        .i_a      (w_aluA),
        .i_b      (w_aluB),
        .i_op     (w_aluOp),
        .o_result (w_aluResult),
        .o_eq     (w_aluEq)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic; memory states wait for an accepted handshake
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FETCH:  if (w_fetchDone) w_nextState = DECODE;
            DECODE: w_nextState = EXEC;
            EXEC: begin
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_ADDI, OP_ORI, OP_LHI, OP_LLI: w_nextState = WB;
                    OP_LW, OP_SW:                    w_nextState = MEM;
                    OP_HALT:                         w_nextState = HALT;
                    default:                         w_nextState = FETCH;
                endcase
            end
            MEM: begin
                if (w_memDone) begin
                    w_nextState = (w_opcode == OP_LW) ? WB : FETCH;
                end
            end
            WB:      w_nextState = FETCH;
            HALT:    w_nextState = HALT;
            default: w_nextState = FETCH;
        endcase
    end

    // FSM outputs: next values of the registered strobes, following the next state
    always_comb begin
        w_imemReqNext = (w_nextState == FETCH);
        w_dmemReqNext = (w_nextState == MEM);
        w_dmemWeNext  = (w_nextState == MEM) && (w_opcode == OP_SW);
        w_haltedNext  = (w_nextState == HALT);
    end

    // Datapath registers and registered interface outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir        <= '0;
            r_pc        <= WORD_SIZE'(RESET_PC);
            r_a         <= '0;
            r_b         <= '0;
            r_aluOut    <= '0;
            r_mdr       <= '0;
            r_dmemAddr  <= '0;
            r_dmemWdata <= '0;
            r_imemReq   <= 1'b0;
            r_dmemReq   <= 1'b0;
            r_dmemWe    <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_imemReq <= w_imemReqNext;
            r_dmemReq <= w_dmemReqNext;
            r_dmemWe  <= w_dmemWeNext;
            r_halted  <= w_haltedNext;
            case (r_state)
                FETCH: begin
                    if (w_fetchDone) begin
                        r_ir <= imem_rdata[31:0];
                        r_pc <= r_pc + WORD_SIZE'(1);
                    end
                end
                DECODE: begin
                    r_a <= r_regs[w_r2];
                    r_b <= ((w_opcode == OP_BEQ) || (w_opcode == OP_SW)) ? r_regs[w_r1] : r_regs[w_r3];
                end
                EXEC: begin
                    r_aluOut <= w_aluResult;
                    if ((w_opcode == OP_LW) || (w_opcode == OP_SW)) begin
                        r_dmemAddr  <= w_aluResult;
                        r_dmemWdata <= r_b;
                    end
                    // PC already points past the branch, so the target is PC + SE(imm)
                    if ((w_opcode == OP_JMP) || ((w_opcode == OP_BEQ) && w_aluEq)) begin
                        r_pc <= r_pc + w_immSe;
                    end
                end
                MEM: begin
                    if (w_memDone) begin
                        r_mdr <= dmem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register file write-back; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (reset && (r_state == WB)) begin
            r_regs[w_r1] <= (w_opcode == OP_LW) ? r_mdr : r_aluOut;
        end
    end

`ifdef MCORE_RETIRE_CNT_EN
    logic [WORD_SIZE-1:0] r_retired;
    logic                 w_retire;

    assign w_retire = (((r_state == EXEC) || (r_state == MEM) || (r_state == WB)) && (w_nextState == FETCH))
                    || ((r_state == EXEC) && (w_nextState == HALT));
    assign retired  = r_retired;

    // Count each completed instruction, HALT included once on entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + WORD_SIZE'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mcore_seq_datapath.sv
// Directed self-checking bench for mcore_seq_datapath. Instruction memory is
// a small array; the data side returns a fixed load word and logs stores.
module tb_mcore_seq_datapath;

    localparam int W = 32;

    localparam logic [5:0] T_ADD  = 6'h00;
    localparam logic [5:0] T_SUB  = 6'h01;
    localparam logic [5:0] T_AND  = 6'h02;
    localparam logic [5:0] T_OR   = 6'h03;
    localparam logic [5:0] T_ADDI = 6'h04;
    localparam logic [5:0] T_ORI  = 6'h05;
    localparam logic [5:0] T_LHI  = 6'h06;
    localparam logic [5:0] T_LLI  = 6'h07;
    localparam logic [5:0] T_LW   = 6'h08;
    localparam logic [5:0] T_SW   = 6'h09;
    localparam logic [5:0] T_BEQ  = 6'h0A;
    localparam logic [5:0] T_JMP  = 6'h0B;
    localparam logic [5:0] T_NOP  = 6'h3E;
    localparam logic [5:0] T_HALT = 6'h3F;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic          imem_ready = 1'b1;
    logic [W-1:0]  imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [W-1:0]  dmem_addr;
    logic [W-1:0]  dmem_wdata;
    logic          dmem_ready = 1'b1;
    logic [W-1:0]  dmem_rdata;
    logic          halted;
    logic [W-1:0]  pc_out;
`ifdef MCORE_RETIRE_CNT_EN
    logic [W-1:0]  retired;
`endif

    logic [31:0]   imem [0:63];
    logic [W-1:0]  loadData = '0;
    int            storeCount = 0;
    logic [W-1:0]  lastStoreAddr = '0;
    logic [W-1:0]  lastStoreData = '0;

    int vecCount = 0;
    int missCount = 0;

    mcore_seq_datapath #(
        .WORD_SIZE (W),
        .NUM_REGS  (32),
        .RESET_PC  (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .halted     (halted),
        .pc_out     (pc_out)
`ifdef MCORE_RETIRE_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr < 64) ? imem[imem_addr[5:0]] : 32'h0;
    assign dmem_rdata = loadData;

    // Log every accepted store so the bench can see what reached memory
    always @(posedge clk) begin
        if (dmem_req && dmem_ready && dmem_we) begin
            storeCount    <= storeCount + 1;
            lastStoreAddr <= dmem_addr;
            lastStoreData <= dmem_wdata;
        end
    end

    function automatic logic [31:0] encR(input logic [5:0] op, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [4:0] r3);
        return {op, r1, r2, r3, 11'h000};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [15:0] imm);
        return {op, r1, r2, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearImem();
        for (int i = 0; i < 64; i++) imem[i] = {T_NOP, 26'h0};
    endtask

    // Hold reset for two edges, then release it between edges
    task automatic startProgram();
        reset = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Step until a fetch of 'addr' is pending; cycles = -1 if it never shows up
    task automatic runUntilFetch(input logic [W-1:0] addr, input int maxCycles, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!(imem_req && imem_addr == addr) && cycles < maxCycles);
        if (!(imem_req && imem_addr == addr)) cycles = -1;
    endtask

    task automatic test_reset();
        clearImem();
        reset = 1'b0;
        tick();
        tick();
        vecCount++; if (imem_req !== 1'b0) begin missCount++; $display("[TB] FAIL reset_imem_req: got %0b want 0", imem_req); end
        vecCount++; if (dmem_req !== 1'b0) begin missCount++; $display("[TB] FAIL reset_dmem_req: got %0b want 0", dmem_req); end
        vecCount++; if (dmem_we !== 1'b0) begin missCount++; $display("[TB] FAIL reset_dmem_we: got %0b want 0", dmem_we); end
        vecCount++; if (halted !== 1'b0) begin missCount++; $display("[TB] FAIL reset_halted: got %0b want 0", halted); end
        vecCount++; if (pc_out !== 32'h0) begin missCount++; $display("[TB] FAIL reset_pc: got %h want 0", pc_out); end
        vecCount++; if (imem_addr !== 32'h0) begin missCount++; $display("[TB] FAIL reset_imem_addr: got %h want 0", imem_addr); end
        vecCount++; if (dmem_addr !== 32'h0) begin missCount++; $display("[TB] FAIL reset_dmem_addr: got %h want 0", dmem_addr); end
        vecCount++; if (dmem_wdata !== 32'h0) begin missCount++; $display("[TB] FAIL reset_dmem_wdata: got %h want 0", dmem_wdata); end
`ifdef MCORE_RETIRE_CNT_EN
        vecCount++; if (retired !== 32'h0) begin missCount++; $display("[TB] FAIL reset_retired: got %0d want 0", retired); end
`endif
        // ready is already high here; it must be ignored while no request is up
        reset = 1'b1;
        tick();
        vecCount++; if (imem_req !== 1'b1) begin missCount++; $display("[TB] FAIL first_req: got %0b want 1", imem_req); end
        vecCount++; if (pc_out !== 32'h0) begin missCount++; $display("[TB] FAIL ready_ignored_pc: got %h want 0", pc_out); end
        tick();
        vecCount++; if (pc_out !== 32'h1 || imem_req !== 1'b0) begin missCount++; $display("[TB] FAIL first_fetch: pc %h req %0b want pc 1 req 0", pc_out, imem_req); end
    endtask

    task automatic test_add();
        int n;
        clearImem();
        imem[0]  = encI(T_LHI, 2, 0, 16'h0000);
        imem[1]  = encI(T_LLI, 2, 0, 16'h0005);
        imem[2]  = encI(T_LHI, 3, 0, 16'h0000);
        imem[3]  = encI(T_LLI, 3, 0, 16'h0007);
        imem[4]  = encR(T_ADD, 3, 2, 3);
        imem[5]  = encR(T_SUB, 5, 3, 2);
        imem[6]  = encR(T_AND, 6, 3, 2);
        imem[7]  = encR(T_OR, 7, 3, 2);
        imem[8]  = encI(T_ADDI, 8, 2, 16'hFFFD);
        imem[9]  = encI(T_ORI, 9, 2, 16'h8000);
        imem[10] = encR(T_SUB, 10, 2, 3);
        imem[11] = {T_HALT, 26'h0};
        startProgram();
        runUntilFetch(4, 40, n);
        vecCount++; if (n < 0) begin missCount++; $display("[TB] FAIL add_reach: fetch of 4 not seen"); end
        tick();
        vecCount++; if (pc_out !== 32'h5) begin missCount++; $display("[TB] FAIL add_pc_inc: got %h want 5", pc_out); end
        runUntilFetch(5, 10, n);
        vecCount++; if (n + 1 !== 4) begin missCount++; $display("[TB] FAIL add_latency: got %0d want 4", n + 1); end
        vecCount++; if (dut.r_regs[3] !== 32'd12) begin missCount++; $display("[TB] FAIL add_result: got %h want c", dut.r_regs[3]); end
    endtask

    task automatic test_alu();
        int n;
        runUntilFetch(11, 40, n);
        vecCount++; if (n < 0) begin missCount++; $display("[TB] FAIL alu_reach: fetch of 11 not seen"); end
        vecCount++; if (dut.r_regs[5] !== 32'd7) begin missCount++; $display("[TB] FAIL sub: got %h want 7", dut.r_regs[5]); end
        vecCount++; if (dut.r_regs[6] !== 32'd4) begin missCount++; $display("[TB] FAIL and: got %h want 4", dut.r_regs[6]); end
        vecCount++; if (dut.r_regs[7] !== 32'd13) begin missCount++; $display("[TB] FAIL or: got %h want d", dut.r_regs[7]); end
        vecCount++; if (dut.r_regs[8] !== 32'd2) begin missCount++; $display("[TB] FAIL addi_neg: got %h want 2", dut.r_regs[8]); end
        vecCount++; if (dut.r_regs[9] !== 32'h0000_8005) begin missCount++; $display("[TB] FAIL ori_ze: got %h want 8005", dut.r_regs[9]); end
        vecCount++; if (dut.r_regs[10] !== 32'hFFFF_FFF9) begin missCount++; $display("[TB] FAIL sub_wrap: got %h want fffffff9", dut.r_regs[10]); end
    endtask

    task automatic test_lhi_lli();
        int n;
        logic [31:0] obs;
        clearImem();
        imem[0] = encI(T_LHI, 4, 0, 16'h1234);
        imem[1] = encI(T_LLI, 4, 0, 16'h5678);
        imem[2] = encI(T_LHI, 4, 0, 16'hABCD);
        imem[3] = {T_HALT, 26'h0};
        startProgram();
        runUntilFetch(1, 20, n);
        obs = dut.r_regs[4];
        vecCount++; if (obs[31:16] !== 16'h1234) begin missCount++; $display("[TB] FAIL lhi_high: got %h want 1234", obs[31:16]); end
        runUntilFetch(2, 10, n);
        vecCount++; if (n !== 4) begin missCount++; $display("[TB] FAIL lli_latency: got %0d want 4", n); end
        vecCount++; if (dut.r_regs[4] !== 32'h1234_5678) begin missCount++; $display("[TB] FAIL lhi_lli: got %h want 12345678", dut.r_regs[4]); end
        runUntilFetch(3, 10, n);
        vecCount++; if (dut.r_regs[4] !== 32'hABCD_5678) begin missCount++; $display("[TB] FAIL lhi_keep_low: got %h want abcd5678", dut.r_regs[4]); end
    endtask

    task automatic test_load();
        int n;
        int reqCycles;
        bit addrOk;
        clearImem();
        imem[0] = encI(T_LHI, 2, 0, 16'h0000);
        imem[1] = encI(T_LLI, 2, 0, 16'h0010);
        imem[2] = encI(T_LW, 7, 2, 16'h0004);
        imem[3] = {T_HALT, 26'h0};
        loadData = 32'hDEAD_BEEF;
        startProgram();
        runUntilFetch(2, 30, n);
        vecCount++; if (n < 0) begin missCount++; $display("[TB] FAIL lw_reach: fetch of 2 not seen"); end
        dmem_ready = 1'b0;
        reqCycles = 0;
        addrOk = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (dmem_req) begin
                reqCycles++;
                if (dmem_addr !== 32'h14 || dmem_we !== 1'b0) addrOk = 1'b0;
            end
            if (c == 5) dmem_ready = 1'b1;
            if (c == 6 && dmem_req !== 1'b0) begin vecCount++; missCount++; $display("[TB] FAIL lw_req_drop: got 1 want 0"); end
        end
        vecCount++; if (reqCycles !== 3) begin missCount++; $display("[TB] FAIL lw_req_cycles: got %0d want 3", reqCycles); end
        vecCount++; if (addrOk !== 1'b1) begin missCount++; $display("[TB] FAIL lw_addr_stable: got %0b want 1", addrOk); end
        vecCount++; if (!(imem_req === 1'b1 && imem_addr === 32'h3)) begin missCount++; $display("[TB] FAIL lw_latency7: req %0b addr %h want 1/3", imem_req, imem_addr); end
        vecCount++; if (dut.r_regs[7] !== 32'hDEAD_BEEF) begin missCount++; $display("[TB] FAIL lw_data: got %h want deadbeef", dut.r_regs[7]); end
    endtask

    task automatic test_store_reset();
        int n;
        int storesBefore;
        clearImem();
        imem[0] = encI(T_LHI, 2, 0, 16'h0000);
        imem[1] = encI(T_LLI, 2, 0, 16'h0020);
        imem[2] = encI(T_LHI, 3, 0, 16'h0000);
        imem[3] = encI(T_LLI, 3, 0, 16'h0055);
        imem[4] = encI(T_SW, 3, 2, 16'h0001);
        imem[5] = encI(T_SW, 3, 2, 16'h0002);
        imem[6] = {T_HALT, 26'h0};
        startProgram();
        runUntilFetch(4, 40, n);
        storesBefore = storeCount;
        tick(); tick(); tick();
        vecCount++; if (!(dmem_req === 1'b1 && dmem_we === 1'b1)) begin missCount++; $display("[TB] FAIL sw_req: req %0b we %0b want 1/1", dmem_req, dmem_we); end
        vecCount++; if (dmem_addr !== 32'h21 || dmem_wdata !== 32'h55) begin missCount++; $display("[TB] FAIL sw_bus: addr %h data %h want 21/55", dmem_addr, dmem_wdata); end
        tick();
        vecCount++; if (!(imem_req === 1'b1 && imem_addr === 32'h5)) begin missCount++; $display("[TB] FAIL sw_latency4: req %0b addr %h want 1/5", imem_req, imem_addr); end
        vecCount++; if (storeCount !== storesBefore + 1 || lastStoreAddr !== 32'h21 || lastStoreData !== 32'h55) begin
            missCount++; $display("[TB] FAIL sw_write: count %0d addr %h data %h want %0d/21/55", storeCount, lastStoreAddr, lastStoreData, storesBefore + 1);
        end
        // Second store is left pending and then abandoned by reset
        dmem_ready = 1'b0;
        tick(); tick(); tick();
        vecCount++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h22) begin missCount++; $display("[TB] FAIL sw2_pending: req %0b addr %h want 1/22", dmem_req, dmem_addr); end
        storesBefore = storeCount;
        reset = 1'b0;
        #1;
        vecCount++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin missCount++; $display("[TB] FAIL rst_dmem_drop: req %0b we %0b want 0/0", dmem_req, dmem_we); end
        vecCount++; if (imem_addr !== 32'h0 || pc_out !== 32'h0) begin missCount++; $display("[TB] FAIL rst_pc: addr %h pc %h want 0/0", imem_addr, pc_out); end
        dmem_ready = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        vecCount++; if (!(imem_req === 1'b1 && imem_addr === 32'h0)) begin missCount++; $display("[TB] FAIL rst_refetch: req %0b addr %h want 1/0", imem_req, imem_addr); end
        vecCount++; if (storeCount !== storesBefore) begin missCount++; $display("[TB] FAIL rst_no_store: got %0d want %0d", storeCount, storesBefore); end
    endtask

    task automatic test_branch();
        int n;
        clearImem();
        imem[0]  = encI(T_LHI, 1, 0, 16'h0000);
        imem[1]  = encI(T_LLI, 1, 0, 16'h0003);
        imem[2]  = encI(T_LHI, 2, 0, 16'h0000);
        imem[3]  = encI(T_LLI, 2, 0, 16'h0003);
        imem[4]  = encI(T_LHI, 5, 0, 16'h0000);
        imem[5]  = encI(T_LLI, 5, 0, 16'h0009);
        imem[6]  = encI(T_JMP, 0, 0, 16'h0003);
        imem[9]  = encI(T_BEQ, 1, 5, 16'h0005);
        imem[10] = encI(T_BEQ, 1, 2, 16'hFFFE);
        imem[11] = {T_HALT, 26'h0};
        startProgram();
        runUntilFetch(6, 40, n);
        vecCount++; if (n < 0) begin missCount++; $display("[TB] FAIL br_reach: fetch of 6 not seen"); end
        runUntilFetch(10, 10, n);
        vecCount++; if (n !== 3) begin missCount++; $display("[TB] FAIL jmp_fwd: cycles %0d want 3 to addr a", n); end
        runUntilFetch(9, 10, n);
        vecCount++; if (n !== 3) begin missCount++; $display("[TB] FAIL beq_taken: cycles %0d want 3 to addr 9", n); end
        imem[10] = encI(T_BEQ, 1, 5, 16'hFFFE);
        runUntilFetch(10, 10, n);
        vecCount++; if (n !== 3) begin missCount++; $display("[TB] FAIL beq_not_taken9: cycles %0d want 3 to addr a", n); end
        runUntilFetch(11, 10, n);
        vecCount++; if (n !== 3) begin missCount++; $display("[TB] FAIL beq_not_taken10: cycles %0d want 3 to addr b", n); end
    endtask

    task automatic test_halt();
        int n;
        bit quiet;
        clearImem();
        imem[0] = {T_NOP, 26'h0};
        imem[1] = encI(T_ORI, 1, 1, 16'h0000);
        imem[2] = {T_NOP, 26'h0};
        imem[3] = {T_HALT, 26'h0};
        imem[4] = encR(T_ADD, 1, 1, 1);
        startProgram();
        tick();
        imem_ready = 1'b0;
        tick(); tick();
        vecCount++; if (!(imem_req === 1'b1 && imem_addr === 32'h0 && pc_out === 32'h0)) begin
            missCount++; $display("[TB] FAIL fetch_stall: req %0b addr %h pc %h want 1/0/0", imem_req, imem_addr, pc_out);
        end
        imem_ready = 1'b1;
        runUntilFetch(1, 10, n);
        vecCount++; if (n !== 3) begin missCount++; $display("[TB] FAIL nop_latency: got %0d want 3", n); end
        runUntilFetch(3, 20, n);
        vecCount++; if (n !== 7) begin missCount++; $display("[TB] FAIL ori_nop_latency: got %0d want 7", n); end
        vecCount++; if (halted !== 1'b0) begin missCount++; $display("[TB] FAIL halted_early: got %0b want 0", halted); end
        tick(); tick(); tick();
        vecCount++; if (halted !== 1'b1 || pc_out !== 32'h4) begin missCount++; $display("[TB] FAIL halt_entry: halted %0b pc %h want 1/4", halted, pc_out); end
        quiet = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1) quiet = 1'b0;
        end
        vecCount++; if (quiet !== 1'b1) begin missCount++; $display("[TB] FAIL halt_terminal: got %0b want 1", quiet); end
`ifdef MCORE_RETIRE_CNT_EN
        vecCount++; if (retired !== 32'd4) begin missCount++; $display("[TB] FAIL retired_count: got %0d want 4", retired); end
`endif
    endtask

    initial begin
        $display("[TB] starting mcore_seq_datapath directed tests");
        test_reset();
        test_add();
        test_alu();
        test_lhi_lli();
        test_load();
        test_store_reset();
        test_branch();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
